// File: rtl/nbody_pkg.sv
// nbody_pkg: shared record layouts, field count and loader state encoding
package nbody_pkg;
  localparam int FIELDS_PER_BODY = 5;
  typedef struct packed {
    logic [15:0] mass;
    logic [15:0] pos_x;
    logic [15:0] pos_y;
    logic [15:0] vel_x;
    logic [15:0] vel_y;
  } body_rec_t;
  typedef struct packed {
    logic [15:0] fx;
    logic [15:0] fy;
  } force_t;
  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_CLEAR,
    S_START,
    S_WAIT,
    S_FINISH
  } load_state_e;
endpackage

// File: rtl/nbody_field_packer.sv
// nbody_field_packer: beat counter and field slots assembling one body record
module nbody_field_packer import nbody_pkg::*; (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear_i,
  input  logic        accept_i,
  input  logic [15:0] data_i,
  output body_rec_t   rec_o,
  output logic        done_o
);
  logic [2:0] beat_q, beat_d;
  logic [0:FIELDS_PER_BODY-1][15:0] slot_q, slot_d;
  assign done_o = accept_i && (beat_q == 3'(FIELDS_PER_BODY - 1));
  // slot 0 (mass) lands in the most significant field of the record
  assign rec_o = body_rec_t'(slot_q);
  always_comb begin
    beat_d = beat_q;
    slot_d = slot_q;
    if (clear_i) beat_d = '0;
    else if (accept_i) begin
      slot_d[beat_q] = data_i;
      beat_d = done_o ? '0 : beat_q + 3'd1;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat_q <= '0;
      slot_q <= '0;
    end else begin
      beat_q <= beat_d;
      slot_q <= slot_d;
    end
  end
endmodule

// File: rtl/nbody_body_loader.sv
// nbody_body_loader: packs body field beats into RAM records, zeroes forces, then runs the simulator
module nbody_body_loader import nbody_pkg::*; #(
  parameter int N          = 2,
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 80,
  parameter int BODY_BASE  = 0,
  parameter int FORCE_BASE = 400
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   load_go,
  input  logic [15:0]            in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DATA_W-1:0]      ram_data,
  output logic [ADDR_W-1:0]      ram_wraddress,
  output logic                   ram_wren,
  output logic                   sim_start,
  input  logic                   sim_done,
  output logic                   busy,
  output logic                   load_done,
  output logic [$clog2(N+1)-1:0] body_count
);
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  if (DATA_W != FIELDS_PER_BODY * 16) begin : g_bad_width
    $error("nbody_body_loader: DATA_W must equal 80");
  end
  if (BODY_BASE + N > 2 ** ADDR_W || FORCE_BASE + N > 2 ** ADDR_W ||
      !(BODY_BASE + N <= FORCE_BASE || FORCE_BASE + N <= BODY_BASE)) begin : g_bad_map
    $error("nbody_body_loader: body and force regions overflow or overlap");
  end
  load_state_e state_q, state_d;
  logic [CW-1:0] count_q, count_d, clr_q, clr_d;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] addr_q;
  logic pk_clear, pk_done;
  body_rec_t rec;
  nbody_field_packer u_packer (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear_i  (pk_clear),
    .accept_i (in_valid && in_ready),
    .data_i   (in_data),
    .rec_o    (rec),
    .done_o   (pk_done)
  );
  assign in_ready   = (state_q == S_COLLECT);
  assign busy       = (state_q != S_IDLE);
  assign body_count = count_q;
  // RAM bus holds its last driven value while ram_wren is low
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    clr_d         = clr_q;
    pk_clear      = 1'b0;
    ram_wren      = 1'b0;
    ram_data      = data_q;
    ram_wraddress = addr_q;
    sim_start     = 1'b0;
    load_done     = 1'b0;
    case (state_q)
      S_IDLE: if (load_go) begin
        state_d  = S_COLLECT;
        count_d  = '0;
        pk_clear = 1'b1;
      end
      S_COLLECT: state_d = pk_done ? S_WRITE : S_COLLECT;
      S_WRITE: begin
        ram_wren      = 1'b1;
        ram_data      = DATA_W'(rec);
        ram_wraddress = ADDR_W'(BODY_BASE) + ADDR_W'(count_q);
        count_d       = count_q + CW'(1);
        clr_d         = '0;
        state_d       = (count_q == LAST) ? S_CLEAR : S_COLLECT;
      end
      S_CLEAR: begin
        ram_wren      = 1'b1;
        ram_data      = '0;
        ram_wraddress = ADDR_W'(FORCE_BASE) + ADDR_W'(clr_q);
        clr_d         = clr_q + CW'(1);
        state_d       = (clr_q == LAST) ? S_START : S_CLEAR;
      end
      // sim_done is deliberately not looked at here so a stale done cannot end the load
      S_START: begin
        sim_start = 1'b1;
        state_d   = S_WAIT;
      end
      S_WAIT: state_d = sim_done ? S_FINISH : S_WAIT;
      S_FINISH: begin
        load_done = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      clr_q   <= '0;
      data_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      clr_q   <= clr_d;
      data_q  <= ram_data;
      addr_q  <= ram_wraddress;
    end
  end
endmodule

// File: tb/tb_nbody_body_loader.sv
// tb_nbody_body_loader: randomized directed bench for the body loader against a write-list reference model
module tb_nbody_body_loader;
  localparam int BB = 0;
  localparam int FB = 400;
  logic clk = 0, reset_n = 0, load_go = 0, in_valid = 0, sim_done = 0, sel5 = 0;
  logic [15:0] in_data = 0;
  logic in_ready2, ram_wren2, sim_start2, busy2, load_done2;
  logic [79:0] ram_data2;
  logic [14:0] addr2;
  logic [1:0] bc2;
  logic in_ready5, ram_wren5, sim_start5, busy5, load_done5;
  logic [79:0] ram_data5;
  logic [14:0] addr5;
  logic [2:0] bc5;
  always #5 clk = ~clk;
  nbody_body_loader #(.N(2), .ADDR_W(15), .DATA_W(80), .BODY_BASE(BB), .FORCE_BASE(FB)) u_dut (
    .clk(clk), .reset_n(reset_n), .load_go(load_go & ~sel5), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready2), .ram_data(ram_data2), .ram_wraddress(addr2),
    .ram_wren(ram_wren2), .sim_start(sim_start2), .sim_done(sim_done), .busy(busy2),
    .load_done(load_done2), .body_count(bc2));
  nbody_body_loader #(.N(5), .ADDR_W(15), .DATA_W(80), .BODY_BASE(BB), .FORCE_BASE(FB)) u_dut5 (
    .clk(clk), .reset_n(reset_n), .load_go(load_go & sel5), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready5), .ram_data(ram_data5), .ram_wraddress(addr5),
    .ram_wren(ram_wren5), .sim_start(sim_start5), .sim_done(sim_done), .busy(busy5),
    .load_done(load_done5), .body_count(bc5));
  typedef struct {
    logic [14:0] a;
    logic [79:0] d;
    int c;
  } wr_t;
  wr_t wr2[$], wr5[$];
  int acc2[$], acc5[$];
  int st2, st5, ld2, ld5, ov2, ov5;
  int cyc = 0;
  int n_tests = 0, n_fail = 0;
  logic [15:0] beats[$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (ram_wren2) wr2.push_back('{addr2, ram_data2, cyc});
    if (ram_wren5) wr5.push_back('{addr5, ram_data5, cyc});
    if (in_valid && in_ready2) acc2.push_back(cyc);
    if (in_valid && in_ready5) acc5.push_back(cyc);
    if (sim_start2) st2++;
    if (sim_start5) st5++;
    if (load_done2) ld2++;
    if (load_done5) ld5++;
    if (ram_wren2 && in_ready2) ov2++;
    if (ram_wren5 && in_ready5) ov5++;
  end
  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clear_logs();
    wr2.delete(); wr5.delete(); acc2.delete(); acc5.delete();
    st2 = 0; st5 = 0; ld2 = 0; ld5 = 0; ov2 = 0; ov5 = 0;
  endtask
  task automatic rand_beats(input int n);
    beats.delete();
    for (int i = 0; i < 5 * n; i++) beats.push_back(16'($urandom));
  endtask
  task automatic pulse_go();
    load_go = 1;
    tick();
    load_go = 0;
  endtask
  task automatic send(input logic [15:0] b, input bit stall);
    bit took = 0;
    if (stall) begin
      in_valid = 0;
      tick();
    end
    in_data = b;
    in_valid = 1;
    for (int g = 0; g < 50 && !took; g++) begin
      @(negedge clk);
      took = sel5 ? in_ready5 : in_ready2;
      tick();
    end
    chk("handshake", took, 1);
  endtask
  task automatic send_range(input int from, input int to, input bit stall);
    for (int i = from; i < to; i++) send(beats[i], stall);
    in_valid = 0;
  endtask
  task automatic wait_start();
    bit seen = 0;
    for (int g = 0; g < 100 && !seen; g++) begin
      @(negedge clk);
      seen = sel5 ? sim_start5 : sim_start2;
    end
    chk("sim_start_seen", seen, 1);
    tick();
  endtask
  task automatic finish_load(input int dly);
    bit seen = 0;
    repeat (dly) tick();
    sim_done = 1;
    for (int g = 0; g < 50 && !seen; g++) begin
      @(negedge clk);
      seen = sel5 ? load_done5 : load_done2;
    end
    chk("load_done_seen", seen, 1);
    chk("busy_at_load_done", sel5 ? busy5 : busy2, 1);
    tick();
    sim_done = 0;
    @(negedge clk);
    chk("busy_after_done", sel5 ? busy5 : busy2, 0);
    chk("load_done_one_cycle", sel5 ? load_done5 : load_done2, 0);
    tick();
  endtask
  // expected RAM write list: n body records in order, then n zeroed force words
  task automatic verify(input int n, input string tag);
    wr_t w[$];
    int a[$];
    if (sel5) begin w = wr5; a = acc5; end
    else begin w = wr2; a = acc2; end
    chk({tag, "_nwrites"}, w.size(), 2 * n);
    chk({tag, "_naccepts"}, a.size(), 5 * n);
    chk({tag, "_starts"}, sel5 ? st5 : st2, 1);
    chk({tag, "_dones"}, sel5 ? ld5 : ld2, 1);
    chk({tag, "_ready_in_write"}, sel5 ? ov5 : ov2, 0);
    if (w.size() == 2 * n && a.size() == 5 * n) begin
      for (int b = 0; b < n; b++) begin
        logic [79:0] e = 0;
        for (int f = 0; f < 5; f++) e = {e[63:0], beats[5 * b + f]};
        chk($sformatf("%s_body%0d_addr", tag, b), w[b].a, BB + b);
        chk($sformatf("%s_body%0d_data", tag, b), w[b].d, e);
        chk($sformatf("%s_body%0d_cycle", tag, b), w[b].c, a[5 * b + 4] + 1);
      end
      for (int k = 0; k < n; k++) begin
        chk($sformatf("%s_clr%0d_addr", tag, k), w[n + k].a, FB + k);
        chk($sformatf("%s_clr%0d_data", tag, k), w[n + k].d, 0);
        chk($sformatf("%s_clr%0d_cycle", tag, k), w[n + k].c, w[n - 1].c + 1 + k);
      end
    end
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready2, 0);
    chk("rst_wren", ram_wren2, 0);
    chk("rst_data", ram_data2, 0);
    chk("rst_addr", addr2, 0);
    chk("rst_start", sim_start2, 0);
    chk("rst_busy", busy2, 0);
    chk("rst_load_done", load_done2, 0);
    chk("rst_body_count", bc2, 0);
    chk("rst_busy5", busy5, 0);
    reset_n = 1;
    tick();
    // basic load with fixed beats and continuous valid
    clear_logs();
    beats = '{16'h0010, 16'h0001, 16'h0002, 16'h0003, 16'h0004,
              16'h0020, 16'h0005, 16'h0006, 16'h0007, 16'h0008};
    pulse_go();
    send_range(0, 10, 0);
    wait_start();
    finish_load(10);
    verify(2, "basic");
    chk("basic_rec0_const", wr2[0].d, 80'h0010_0001_0002_0003_0004);
    chk("basic_rec1_const", wr2[1].d, 80'h0020_0005_0006_0007_0008);
    chk("basic_clr1_addr", wr2[3].a, 15'h191);
    chk("basic_body_count", bc2, 2);
    // stalled stream
    clear_logs();
    rand_beats(2);
    pulse_go();
    send_range(0, 10, 1);
    wait_start();
    finish_load(3);
    verify(2, "stall");
    // stale done held through START
    clear_logs();
    rand_beats(2);
    pulse_go();
    send_range(0, 10, 0);
    sim_done = 1;
    wait_start();
    sim_done = 0;
    repeat (5) tick();
    chk("stale_no_done", ld2, 0);
    chk("stale_busy", busy2, 1);
    finish_load(2);
    verify(2, "stale");
    // reset in the middle of body 1
    clear_logs();
    rand_beats(2);
    pulse_go();
    send_range(0, 8, 0);
    reset_n = 0;
    #1;
    chk("midrst_in_ready", in_ready2, 0);
    chk("midrst_wren", ram_wren2, 0);
    chk("midrst_data", ram_data2, 0);
    chk("midrst_addr", addr2, 0);
    chk("midrst_busy", busy2, 0);
    chk("midrst_body_count", bc2, 0);
    clear_logs();
    in_valid = 1;
    tick();
    tick();
    reset_n = 1;
    repeat (6) tick();
    in_valid = 0;
    chk("midrst_no_writes", wr2.size(), 0);
    chk("midrst_no_accepts", acc2.size(), 0);
    clear_logs();
    rand_beats(2);
    pulse_go();
    send_range(0, 10, 0);
    wait_start();
    finish_load(4);
    verify(2, "fresh");
    // beats offered in IDLE and load_go while busy
    clear_logs();
    in_valid = 1;
    in_data = 16'hbeef;
    repeat (4) tick();
    in_valid = 0;
    chk("idle_no_accepts", acc2.size(), 0);
    chk("idle_no_writes", wr2.size(), 0);
    chk("idle_body_count", bc2, 2);
    rand_beats(2);
    pulse_go();
    send_range(0, 2, 0);
    pulse_go();
    send_range(2, 10, 0);
    wait_start();
    pulse_go();
    chk("busy_go_body_count", bc2, 2);
    chk("busy_go_busy", busy2, 1);
    finish_load(2);
    verify(2, "busygo");
    // N=5 instance
    sel5 = 1;
    clear_logs();
    rand_beats(5);
    pulse_go();
    send_range(0, 25, 0);
    wait_start();
    finish_load(4);
    verify(5, "n5");
    chk("n5_body_count", bc5, 5);
    chk("n5_other_idle", wr2.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/nbody_body_loader.md
Name: nbody_body_loader

Overview:
- Write-side front end for the N-body engine.
- Accepts a 16-bit field stream over a valid/ready handshake and packs five fields per body into one 80-bit record.
- Writes the records into the body region of the 2-port RAM through its write port, then zeroes the force region.
- Finally pulses start to the simulator and holds busy until the simulator reports done; it is the writer counterpart to the force read-back path.

Parameters:
- N, 2: number of bodies per load.
- ADDR_W, 15: RAM address width.
- DATA_W, 80: RAM word width; fixed at 5 x 16.
- BODY_BASE, 0: RAM address of body 0 record.
- FORCE_BASE, 400 (0x190): RAM address of the force word for body 0.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- load_go  in  1  one-cycle request to begin a load; sampled only in IDLE.
- in_data  in  16  field beat.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts beat; a beat transfers when in_valid and in_ready are both high.
- ram_data  out  DATA_W  RAM write data.
- ram_wraddress  out  ADDR_W  RAM write address.
- ram_wren  out  1  RAM write enable.
- sim_start  out  1  one-cycle start pulse to the simulator.
- sim_done  in  1  simulator completion (level).
- busy  out  1  high in every state except IDLE.
- load_done  out  1  one-cycle pulse after sim_done is seen.
- body_count  out  $clog2(N+1)  bodies written so far in the current load.

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0: in_ready, ram_wren, ram_data, ram_wraddress, sim_start, busy, load_done, body_count. The field assembly register and beat counter are cleared. Reset mid-load abandons the load; the partial record is never written.
- Field order per body, beats 0..4:
  - mass -> [79:64]
  - pos_x -> [63:48]
  - pos_y -> [47:32]
  - vel_x -> [31:16]
  - vel_y -> [15:0]
  - All fields are raw 16-bit two's complement; no arithmetic is applied.
- IDLE: in_ready=0. When load_go=1, go to COLLECT and clear body_count and the beat counter.
- COLLECT: in_ready=1. Each transfer stores in_data into the slot selected by the beat counter, then increments the counter (0..4). The transfer of beat 4 moves to WRITE. in_valid low stalls with no state change.
- WRITE, exactly one cycle:
  - in_ready=0, ram_wren=1, ram_data = assembled record, ram_wraddress = BODY_BASE + body_count.
  - Latency: the write occurs the cycle after beat 4 is accepted.
  - body_count increments at the end of this cycle.
  - If the new body_count equals N, go to CLEAR with index 0; otherwise go to COLLECT.
- CLEAR, N cycles:
  - ram_wren=1, ram_data=0, ram_wraddress = FORCE_BASE + k for k = 0..N-1.
  - After k=N-1, go to START.
- START, one cycle: sim_start=1, ram_wren=0. sim_done is ignored in this cycle, so a stale done cannot end the load. Next state is WAIT.
- WAIT: remain until sim_done=1, then go to FINISH.
- FINISH, one cycle: load_done=1. Next state is IDLE; body_count holds N until the next load_go.
- Back-pressure: beats offered outside COLLECT are not accepted, because in_ready is 0.
- load_go outside IDLE is ignored.
- Address arithmetic is ADDR_W-bit and wraps modulo 2^ADDR_W. BODY_BASE+N-1 and FORCE_BASE+N-1 are required to be below 2^ADDR_W and non-overlapping; the implementation checks this with an elaboration-time assertion.
- ram_data/ram_wraddress hold their last values when ram_wren=0. They are don't-care for the RAM, but the implementation must be deterministic.

Decomposition:
- Package nbody_pkg holds:
  - the body_rec_t packed struct (mass, pos_x, pos_y, vel_x, vel_y, 16 bits each)
  - the force_t packed struct (fx [31:16], fy [15:0])
  - FIELDS_PER_BODY=5
  - the loader state enum.
- One sub-module: nbody_field_packer. It holds the beat counter, field slots, and the record-complete flag, with clear/accept inputs. The FSM and address generation stay in the top.

Test Plan:
- Basic load, N=2, continuous valid: load_go, then beats 0x0010,0x0001,0x0002,0x0003,0x0004 and 0x0020,0x0005,0x0006,0x0007,0x0008.
  - Writes: addr 0 = 80'h0010_0001_0002_0003_0004, then addr 1 = 80'h0020_0005_0006_0007_0008.
  - Then zero writes to 0x190 and 0x191 on consecutive cycles.
  - sim_start pulses exactly once.
  - Drive sim_done 10 cycles later -> load_done pulse; busy falls the cycle after load_done.
- Stalled stream: toggle in_valid every other cycle. The same RAM contents result; there is no write until the 5th accepted beat; in_ready stays 0 during WRITE.
- Stale done: hold sim_done=1 through the START cycle and drop it the next cycle -> remains in WAIT; load_done only after sim_done re-asserts.
- Reset mid-record: after 3 beats of body 1, pulse reset_n low -> no ram_wren afterwards, all outputs 0. A fresh load writes body 0 starting from the mass field.
- load_go while busy, and beats offered in IDLE: no handshake (in_ready=0), no extra writes, and body_count is unchanged.
- N=5 parameter sweep: 25 beats -> 5 body writes at 0..4 and 5 clear writes at 0x190..0x194, in order, with no gaps in the CLEAR phase.
